bcd_down_counter_sync: RTL and testbench
========================================

// Module: bcd_down_counter_sync
// PURPOSE
// - Synchronous, cascadable BCD (decade) down-counter of DIGITS decimal digits.
// - Complements the team's asynchronous up-counting ripple decade counter: all
//   digit registers clock on one edge, so there is no ripple skew.
// - Used as the countdown/timer stage. The borrow output chains into the next
//   counter; the zero/done flags drive control logic.
// PARAMETERS
// - DIGITS  2  number of BCD digits (1..8); the count is 4*DIGITS bits wide.
// - WRAP    1  1 = roll over from all-0 to all-9; 0 = one-shot, stop at all-0.
// PORTS
// - clock       in   1         rising-edge clock.
// - preset      in   1         reset: asynchronous, active-high; forces all digits to 9.
// - load        in   1         synchronous load strobe.
// - load_value  in   4*DIGITS  BCD value to load; digit i is bits [4i+3:4i].
// - enable      in   1         count enable: one decrement per clock while high.
// - count       out  4*DIGITS  current BCD count (registered).
// - zero        out  1         high when count == 0 (decoded from registered count).
// - borrow      out  1         one-cycle pulse on wrap 0 -> 9..9 (WRAP=1 only).
// - done        out  1         sticky terminal flag (WRAP=0 only).
// BEHAVIOUR
// - Reset (preset=1, asynchronous, dominates everything):
//   - count = all 9s (8'h99 when DIGITS=2); borrow = 0; done = 0; zero = 0.
//   - FSM state = RUN.
// - FSM states: RUN, HALT. HALT is reachable only when WRAP=0.
// - Per-edge priority: preset > load > enable > hold.
// - load=1:
//   - count <= load_value on that edge; done <= 0; state <= RUN; borrow <= 0.
//   - enable is ignored on the same edge.
//   - Any digit > 9 in load_value is clamped to 9 (e.g. 4'hC -> 4'h9).
// - enable=1 in RUN, count != 0:
//   - digit 0 decrements by 1; a digit at 0 becomes 9 and borrows into digit i+1.
//   - Borrow propagates combinationally through all digits within one cycle.
//   - Latency: count reflects the decrement on the same rising edge that samples enable.
// - enable=1 in RUN, count == 0:
//   - WRAP=1: count <= all 9s; borrow = 1 for exactly that next cycle.
//   - WRAP=0: count holds 0; done <= 1; state <= HALT; borrow stays 0.
// - HALT: enable is ignored and count holds 0. Only load or preset leaves HALT.
// - enable=0: every register holds; borrow returns to 0 after its single cycle.
// - zero is combinational on count and therefore valid in the same cycle as count.
// - Reset mid-count: preset asserted between edges updates count immediately, with
//   no clock edge needed. On release, counting resumes from all 9s at the next
//   enabled edge.
// - count is always valid BCD; no digit value 4'hA..4'hF is ever produced.
// TESTING (DIGITS=2 unless stated)
// - 1. Preset pulse -> count=8'h99, zero=0, borrow=0, done=0 without waiting for a clock.
// - 2. From 8'h99, 10 enabled clocks -> 8'h89; 9 more -> 8'h80; 1 more -> 8'h79 (digit borrow).
// - 3. WRAP=1: load 8'h01 then 2 enabled clocks -> 8'h00 with zero=1, then 8'h99 with
//      borrow=1 for one cycle only.
// - 4. WRAP=0: load 8'h02 then 5 enabled clocks -> 01, 00, and count holds 00;
//      done=1 and stays 1 until load 8'h10 clears it.
// - 5. load=1 and enable=1 on the same edge with load_value=8'h3C -> count=8'h39
//      (clamped, no decrement).
// - 6. Preset asserted mid-count at 8'h47 -> immediately 8'h99; after release,
//      next enabled clock -> 8'h98.

Source files
------------

// File: rtl/bcd_down_counter_sync.sv
// bcd_down_counter_sync
//
// Synchronous, cascadable BCD (decade) down-counter of DIGITS decimal digits.
// Every digit register clocks on the same rising edge, so the count never shows
// ripple skew.
//
// Parameters
//   DIGITS      number of BCD digits (1..8); the count is 4*DIGITS bits wide
//   WRAP        1 = roll over from all-0 to all-9, 0 = one-shot, stop at all-0
//
// Ports
//   clock       rising-edge clock
//   preset      asynchronous, active-high; forces every digit to 9
//   load        synchronous load strobe (wins over enable)
//   load_value  BCD value to load, digit i in bits [4i+3:4i]; digits above 9 clamp to 9
//   enable      count enable, one decrement per clock while high
//   count       registered BCD count
//   zero        high while count is all zeros
//   borrow      one-cycle pulse after wrapping from 0 to all 9s (WRAP=1 only)
//   done        sticky terminal flag, set on an enabled edge at zero (WRAP=0 only)
module bcd_down_counter_sync #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clock,
  input  logic                  preset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_n;
  logic [W-1:0]   count_n;
  logic           borrow_n;
  logic           done_n;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   dec_value;

  assign zero = (count == '0);

  // Clamp each incoming digit so an illegal BCD code can never enter the count.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  // Decrement with a borrow chain that ripples through all digits combinationally:
  // a digit at 0 becomes 9 and keeps borrowing; the first nonzero digit absorbs it.
  always_comb begin
    logic chain;
    dec_value = count;
    chain     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (chain) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_value[4*i +: 4] = 4'd9;
        end else begin
          dec_value[4*i +: 4] = count[4*i +: 4] - 4'd1;
          chain               = 1'b0;
        end
      end
    end
  end

  // Next-state logic: load beats enable; borrow defaults low so it only lasts
  // the single cycle following a wrap.
  always_comb begin
    state_n  = state_q;
    count_n  = count;
    borrow_n = 1'b0;
    done_n   = done;
    if (load) begin
      count_n = load_clamped;
      done_n  = 1'b0;
      state_n = RUN;
    end else if (enable && (state_q == RUN)) begin
      if (zero) begin
        if (WRAP != 0) begin
          count_n  = NINES;
          borrow_n = 1'b1;
        end else begin
          done_n  = 1'b1;
          state_n = HALT;
        end
      end else begin
        count_n = dec_value;
      end
    end
  end

  // State and output registers; preset acts immediately without a clock edge.
  always_ff @(posedge clock or posedge preset) begin
    if (preset) begin
      state_q <= RUN;
      count   <= NINES;
      borrow  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      count   <= count_n;
      borrow  <= borrow_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter_sync.sv
// tb_bcd_down_counter_sync
//
// Drives a wrapping (WRAP=1) and a one-shot (WRAP=0) two-digit counter from the
// same inputs and compares both against hand-computed expected values.
module tb_bcd_down_counter_sync;

  logic       clock;
  logic       preset;
  logic       load;
  logic [7:0] load_value;
  logic       enable;

  logic [7:0] count_w;
  logic       zero_w;
  logic       borrow_w;
  logic       done_w;
  logic [7:0] count_s;
  logic       zero_s;
  logic       borrow_s;
  logic       done_s;

  int checks = 0;
  int errors = 0;

  bcd_down_counter_sync #(.DIGITS(2), .WRAP(1)) u_wrap (
    .clock      (clock),
    .preset     (preset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count      (count_w),
    .zero       (zero_w),
    .borrow     (borrow_w),
    .done       (done_w)
  );

  bcd_down_counter_sync #(.DIGITS(2), .WRAP(0)) u_stop (
    .clock      (clock),
    .preset     (preset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count      (count_s),
    .zero       (zero_s),
    .borrow     (borrow_s),
    .done       (done_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something unexpected blocks the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       ld;
    logic       en;
    logic [7:0] lv;
    logic [7:0] cw;
    logic       bw;
    logic [7:0] cs;
    logic       ds;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check1(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_cw, input logic exp_bw,
                             input logic [7:0] exp_cs, input logic exp_ds);
    check1({name, " count_w"},  count_w,         exp_cw);
    check1({name, " zero_w"},   {7'd0, zero_w},  {7'd0, (exp_cw == 8'h00)});
    check1({name, " borrow_w"}, {7'd0, borrow_w}, {7'd0, exp_bw});
    check1({name, " done_w"},   {7'd0, done_w},  8'h00);
    check1({name, " count_s"},  count_s,         exp_cs);
    check1({name, " zero_s"},   {7'd0, zero_s},  {7'd0, (exp_cs == 8'h00)});
    check1({name, " borrow_s"}, {7'd0, borrow_s}, 8'h00);
    check1({name, " done_s"},   {7'd0, done_s},  {7'd0, exp_ds});
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic ld, input logic en, input logic [7:0] lv);
    @(negedge clock);
    load       = ld;
    enable     = en;
    load_value = lv;
    @(posedge clock);
    #1;
  endtask

  initial begin
    preset     = 1'b0;
    load       = 1'b0;
    enable     = 1'b0;
    load_value = 8'h00;

    //        ld    en    lv     cw     bw    cs     ds
    vecs[0]  = '{1'b1, 1'b1, 8'h3C, 8'h39, 1'b0, 8'h39, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h99, 1'b1, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h98, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h02, 8'h02, 1'b0, 8'h02, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h99, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h98, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h97, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h97, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 8'h10, 8'h10, 1'b0, 8'h10, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 8'h09, 1'b0, 8'h09, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'hFF, 8'h99, 1'b0, 8'h99, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 8'hA5, 8'h95, 1'b0, 8'h95, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 8'h94, 1'b0, 8'h94, 1'b0};

    // Asynchronous preset before any rising edge.
    #2;
    preset = 1'b1;
    #1;
    checkOutput("preset", 8'h99, 1'b0, 8'h99, 1'b0);
    @(negedge clock);
    preset = 1'b0;

    // Twenty enabled clocks from 99, crossing the 90 -> 89 and 80 -> 79 digit borrows.
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("countdown%0d", k), to_bcd(99 - k), 1'b0, to_bcd(99 - k), 1'b0);
    end

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].en, vecs[i].lv);
      checkOutput($sformatf("vec%0d", i), vecs[i].cw, vecs[i].bw, vecs[i].cs, vecs[i].ds);
    end

    // Drive the one-shot counter into HALT, then preset mid-cycle with no clock edge.
    applyStimulus(1'b1, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("halt_entry", 8'h99, 1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h47);
    checkOutput("load47", 8'h47, 1'b0, 8'h47, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("dec46", 8'h46, 1'b0, 8'h46, 1'b0);
    @(negedge clock);
    enable = 1'b0;
    #2;
    preset = 1'b1;
    #1;
    checkOutput("preset_mid", 8'h99, 1'b0, 8'h99, 1'b0);
    @(negedge clock);
    preset = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("after_preset", 8'h98, 1'b0, 8'h98, 1'b0);

    // Preset must also release the one-shot counter from HALT.
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("halt_again", 8'h99, 1'b1, 8'h00, 1'b1);
    @(negedge clock);
    enable = 1'b0;
    preset = 1'b1;
    #1;
    checkOutput("preset_halt", 8'h99, 1'b0, 8'h99, 1'b0);
    @(negedge clock);
    preset = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("resume_halt", 8'h98, 1'b0, 8'h98, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
